revaluate_stream: RTL and testbench

Parametrised successor of the single-slice revaluation unit in the encoder datapath. Accepts a block of `NSLICE` 25-bit state slices over a valid/ready stream, applies the revaluation function to `LANES` slices per beat, buffers results in an output FIFO and signals block completion. It sits between the previous round step and the next encoder stage, replacing the one-shot start/ready unit for multi-slice operation. It supports back-pressure and a bypass mode.

---
 rtl/rv_pkg.sv | 13 +
 rtl/revaluate_stream_if.sv | 9 +
 rtl/rv_fifo.sv | 52 +++++
 rtl/revaluate_stream.sv | 80 ++++++++
 tb/tb_revaluate_stream.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared constants, FSM states and the per-slice revaluation function.
package rv_pkg;
   localparam int SLICE_W = 25;
   localparam int ROW = 5;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
   function automatic logic [SLICE_W-1:0] reval_slice(input logic [SLICE_W-1:0] s);
      logic [SLICE_W-1:0] r;
      for (int y = 0; y < ROW; y++)
         for (int x = 0; x < ROW; x++)
            r[ROW*y+x] = s[ROW*y+x] ^ (~s[ROW*y+(x+1)%ROW] & s[ROW*y+(x+2)%ROW]);
      return r;
   endfunction
endpackage

// File: rtl/revaluate_stream_if.sv
// revaluate_stream_if: valid/ready stream carrying LANES packed 25-bit slices.
interface revaluate_stream_if #(parameter int LANES = 1);
   import rv_pkg::*;
   logic valid;
   logic ready;
   logic [SLICE_W*LANES-1:0] data;
   modport master(output valid, output data, input ready);
   modport slave(input valid, input data, output ready);
endinterface

// File: rtl/rv_fifo.sv
// rv_fifo: synchronous FIFO with a registered head stage; count includes the head.
module rv_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic [W-1:0] push_data,
   input  logic pop,
   output logic [W-1:0] rd_data,
   output logic rd_valid,
   output logic empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] mcnt_q, mcnt_d;
   logic hv_q, hv_d;
   logic [W-1:0] hd_q, hd_d;
   logic load;
   // head refills from storage whenever it is empty or being consumed
   always_comb begin
      load = (mcnt_q != '0) && (!hv_q || pop);
      wr_d = push ? wr_q + 1'b1 : wr_q;
      rd_d = load ? rd_q + 1'b1 : rd_q;
      mcnt_d = mcnt_q + (AW+1)'(push) - (AW+1)'(load);
      hv_d = load | (hv_q & ~pop);
      hd_d = load ? mem_q[rd_q] : hd_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         mcnt_q <= '0;
         hv_q <= 1'b0;
         hd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         mcnt_q <= mcnt_d;
         hv_q <= hv_d;
         hd_q <= hd_d;
      end
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= push_data;
   assign rd_data = hd_q;
   assign rd_valid = hv_q;
   assign count = mcnt_q + (AW+1)'(hv_q);
   assign empty = count == '0;
endmodule

// File: rtl/revaluate_stream.sv
// revaluate_stream: block-oriented streaming revaluation of LANES slices per beat.
module revaluate_stream
   import rv_pkg::*;
#(
   parameter int LANES = 1,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic bypass,
   input  logic [CNT_W-1:0] nbeats,
   revaluate_stream_if.slave in_s,
   revaluate_stream_if.master out_m,
   output logic busy,
   output logic done
);
   localparam int W = SLICE_W*LANES;
   localparam int CW = $clog2(DEPTH) + 1;
   state_e state_q, state_d;
   logic bypass_q, bypass_d;
   logic [CNT_W-1:0] nbeats_q, nbeats_d, acc_q, acc_d, emit_q, emit_d;
   logic [W-1:0] reval;
   logic push, pop, empty;
   logic [CW-1:0] count;
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign reval[SLICE_W*l +: SLICE_W] = reval_slice(in_s.data[SLICE_W*l +: SLICE_W]);
   end
   assign in_s.ready = (state_q == RUN) && (count < CW'(DEPTH));
   assign push = in_s.valid && in_s.ready;
   assign pop = out_m.valid && out_m.ready;
   rv_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .push_data(bypass_q ? in_s.data : reval),
      .pop(pop),
      .rd_data(out_m.data),
      .rd_valid(out_m.valid),
      .empty(empty),
      .count(count)
   );
   always_comb begin
      state_d = state_q;
      bypass_d = bypass_q;
      nbeats_d = nbeats_q;
      acc_d = acc_q + CNT_W'(push);
      emit_d = emit_q + CNT_W'(pop);
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            bypass_d = bypass;
            nbeats_d = (nbeats == '0) ? CNT_W'(1) : nbeats;
            acc_d = '0;
            emit_d = '0;
         end
         RUN: if (acc_d == nbeats_q) state_d = DRAIN;
         // finishing on the final pop itself lets done follow it by one cycle
         DRAIN: if (emit_d == nbeats_q && (pop || empty)) state_d = DONE;
         DONE: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         bypass_q <= 1'b0;
         nbeats_q <= '0;
         acc_q <= '0;
         emit_q <= '0;
      end else begin
         state_q <= state_d;
         bypass_q <= bypass_d;
         nbeats_q <= nbeats_d;
         acc_q <= acc_d;
         emit_q <= emit_d;
      end
   assign busy = (state_q == RUN) || (state_q == DRAIN);
   assign done = state_q == DONE;
endmodule

// File: tb/tb_revaluate_stream.sv
// tb_revaluate_stream: randomized block-level checks against a row-rotation reference model.
module tb_revaluate_stream;
   localparam int LANES = 4, DEPTH = 4, CNT_W = 8, W = 25*LANES;
   logic clk = 1'b0, rst, start, bypass, busy, done;
   logic [CNT_W-1:0] nbeats;
   int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
   logic busy_at_done;
   logic [W-1:0] got_q[$];
   int pop_cyc[$];
   logic [W-1:0] stim[$];
   revaluate_stream_if #(.LANES(LANES)) in_s();
   revaluate_stream_if #(.LANES(LANES)) out_s();
   revaluate_stream #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .bypass(bypass), .nbeats(nbeats),
      .in_s(in_s), .out_m(out_s), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (out_s.valid && out_s.ready) begin
         got_q.push_back(out_s.data);
         pop_cyc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         busy_at_done = busy;
      end
   end
   function automatic logic [24:0] ref_slice(input logic [24:0] s);
      logic [24:0] r;
      logic [4:0] row, a, b;
      for (int y = 0; y < 5; y++) begin
         row = s[5*y +: 5];
         a = {row[0], row[4:1]};
         b = {row[1:0], row[4:2]};
         r[5*y +: 5] = row ^ (~a & b);
      end
      return r;
   endfunction
   function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic byp);
      logic [W-1:0] r;
      for (int k = 0; k < LANES; k++) r[25*k +: 25] = byp ? d[25*k +: 25] : ref_slice(d[25*k +: 25]);
      return r;
   endfunction
   function automatic logic [W-1:0] rand_beat();
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction
   task automatic run_block(input logic byp, input int n_cfg, input int stall, input bit rrdy,
                            input bit rvld, input int spur, output int acc_at_stall,
                            output logic rdy_at_stall, output bit timeout);
      int n_eff, sent;
      n_eff = (n_cfg == 0) ? 1 : n_cfg;
      sent = 0;
      acc_at_stall = 0;
      rdy_at_stall = 1'b0;
      timeout = 1'b1;
      got_q.delete();
      pop_cyc.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1; bypass = byp; nbeats = CNT_W'(n_cfg);
      @(posedge clk); #1;
      bypass = 1'($urandom_range(0, 1)); nbeats = CNT_W'($urandom);
      for (int c = 0; c < 400; c++) begin
         start = (c == spur);
         if (c == spur) nbeats = CNT_W'(1);
         in_s.valid = (sent < n_eff) && (!rvld || $urandom_range(0, 3) != 0);
         in_s.data = (sent < n_eff) ? stim[sent] : rand_beat();
         out_s.ready = (c >= stall) && (!rrdy || $urandom_range(0, 2) != 0);
         @(negedge clk);
         if (in_s.valid && in_s.ready) sent++;
         if (c == stall - 1) begin
            acc_at_stall = sent;
            rdy_at_stall = in_s.ready;
         end
         @(posedge clk); #1;
         if (done_cnt > 0) begin
            timeout = 1'b0;
            break;
         end
      end
      start = 1'b0; in_s.valid = 1'b0; out_s.ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   task automatic check_block(input string name, input logic byp, input int n_eff, input bit to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s timeout: no done within cycle budget", name);
      end
      checks++;
      if (got_q.size() !== n_eff) begin
         errors++;
         $display("FAIL %s out_count got %0d exp %0d", name, got_q.size(), n_eff);
      end
      for (int i = 0; i < n_eff && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== ref_beat(stim[i], byp)) begin
            errors++;
            $display("FAIL %s beat%0d got %h exp %h", name, i, got_q[i], ref_beat(stim[i], byp));
         end
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s done_pulses got %0d exp 1", name, done_cnt);
      end
      if (pop_cyc.size() > 0) begin
         checks++;
         if (done_cyc - pop_cyc[$] !== 1) begin
            errors++;
            $display("FAIL %s done_latency got %0d exp 1", name, done_cyc - pop_cyc[$]);
         end
      end
      checks++;
      if (busy_at_done !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_at_done got %b exp 0", name, busy_at_done);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bypass = 1'b0; nbeats = '0;
      in_s.valid = 1'b0; in_s.data = '0; out_s.ready = 1'b0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (in_s.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_s.ready); end
      if (out_s.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_s.valid); end
      if (out_s.data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_s.data); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask
   task automatic test_vectors(input logic byp);
      int a; logic r; bit to;
      stim.delete();
      stim.push_back({rand_beat() >> 75, 25'h0000000, 25'h1FFFFFF, 25'h0000001});
      run_block(byp, 1, 0, 0, 0, -1, a, r, to);
      check_block(byp ? "bypass" : "vectors", byp, 1, to);
      if (got_q.size() > 0) begin
         checks += 3;
         if (got_q[0][24:0] !== (byp ? 25'h0000001 : 25'h0000009)) begin
            errors++; $display("FAIL lane0 got %h exp %h", got_q[0][24:0], byp ? 25'h0000001 : 25'h0000009);
         end
         if (got_q[0][49:25] !== 25'h1FFFFFF) begin
            errors++; $display("FAIL lane1_ones got %h exp 1ffffff", got_q[0][49:25]);
         end
         if (got_q[0][74:50] !== 25'h0000000) begin
            errors++; $display("FAIL lane2_zero got %h exp 0", got_q[0][74:50]);
         end
      end
   endtask
   task automatic test_backpressure();
      int a; logic r; bit to;
      stim.delete();
      for (int i = 0; i < 10; i++) stim.push_back(rand_beat());
      run_block(1'b0, 10, 8, 0, 0, -1, a, r, to);
      checks += 2;
      if (a !== 4) begin errors++; $display("FAIL bp_accepts_during_stall got %0d exp 4", a); end
      if (r !== 1'b0) begin errors++; $display("FAIL bp_in_ready_when_full got %b exp 0", r); end
      check_block("backpressure", 1'b0, 10, to);
   endtask
   task automatic test_back_to_back();
      int a; logic r; bit to;
      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(rand_beat());
      run_block(1'b0, 16, 0, 0, 0, -1, a, r, to);
      check_block("stream", 1'b0, 16, to);
      if (pop_cyc.size() == 16) begin
         checks++;
         if (pop_cyc[15] - pop_cyc[0] !== 15) begin
            errors++; $display("FAIL stream_span got %0d exp 15", pop_cyc[15] - pop_cyc[0]);
         end
      end
   endtask
   task automatic test_random();
      int a, n; logic r, byp; bit to;
      for (int t = 0; t < 6; t++) begin
         n = $urandom_range(0, 20);
         byp = 1'($urandom_range(0, 1));
         stim.delete();
         for (int i = 0; i < 20; i++) stim.push_back(rand_beat());
         run_block(byp, n, $urandom_range(0, 6), 1, 1, -1, a, r, to);
         check_block("random", byp, (n == 0) ? 1 : n, to);
      end
   endtask
   task automatic test_reset_mid();
      int sent, a; logic r; bit to;
      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(rand_beat());
      @(posedge clk); #1;
      start = 1'b1; bypass = 1'b0; nbeats = CNT_W'(8); out_s.ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; sent = 0;
      for (int c = 0; c < 50 && sent < 3; c++) begin
         in_s.valid = 1'b1; in_s.data = stim[sent];
         @(negedge clk);
         if (in_s.ready) sent++;
         @(posedge clk); #1;
      end
      rst = 1'b1; in_s.valid = 1'b0;
      #2;
      checks += 5;
      if (sent !== 3) begin errors++; $display("FAIL midrst_accepts got %0d exp 3", sent); end
      if (in_s.ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_s.ready); end
      if (out_s.valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_s.valid); end
      if (out_s.data !== '0) begin errors++; $display("FAIL midrst_out_data got %h exp 0", out_s.data); end
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_busy_done got %b%b exp 00", busy, done); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) stim[i] = rand_beat();
      run_block(1'b0, 5, 2, 0, 0, -1, a, r, to);
      check_block("after_reset", 1'b0, 5, to);
   endtask
   task automatic test_ignore();
      int a; logic r; bit to;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_s.valid = 1'b1; in_s.data = rand_beat();
         @(negedge clk);
         checks++;
         if (in_s.ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready got %b exp 0", in_s.ready); end
      end
      @(posedge clk); #1;
      in_s.valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_s.valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_outputs got valid=%b busy=%b exp 0 0", out_s.valid, busy);
      end
      stim.delete();
      for (int i = 0; i < 6; i++) stim.push_back(rand_beat());
      run_block(1'b0, 6, 10, 0, 0, 2, a, r, to);
      check_block("ignore_start", 1'b0, 6, to);
   endtask
   initial begin
      test_reset();
      test_vectors(1'b0);
      test_vectors(1'b1);
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_ignore();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
